// File: rtl/toggle_seq_ctrl_if.sv
// Handshake and feedback bundle between a burst controller, toggle_seq_ctrl and the driven toggle_ff.
// The master side is the launching environment, which also returns the flop's q.
interface toggle_seq_ctrl_if #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
);
   logic             start;
   logic [CNT_W-1:0] num_toggles;
   logic [GAP_W-1:0] gap;
   logic             abort;
   logic             q_fb;
   logic             t_out;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] toggles_done;

   modport master (
      output start, num_toggles, gap, abort, q_fb,
      input  t_out, busy, done, err, toggles_done
   );

   modport slave (
      input  start, num_toggles, gap, abort, q_fb,
      output t_out, busy, done, err, toggles_done
   );
endinterface

// File: rtl/toggle_seq_ctrl.sv
// Issues a burst of one-cycle t_out pulses with a programmable gap and checks that each
// pulse toggled the downstream flop.
module toggle_seq_ctrl #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   toggle_seq_ctrl_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_CHECK,
      S_GAP,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               exp_q, exp_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   tog_q, tog_d;
   logic               t_out_q, t_out_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      exp_d     = exp_q;
      err_d     = err_q;
      tog_d     = tog_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               cnt_d = bus.num_toggles;
               gap_d = bus.gap;
               if (bus.num_toggles == '0) begin
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  tog_d   = '0;
                  exp_d   = ~bus.q_fb;
                  state_d = S_PULSE;
               end
            end
         end
         S_PULSE: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else begin
               tog_d   = tog_q + 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            // The flop sampled the pulse on the previous edge, so q_fb is settled here.
            if (bus.abort) begin
               state_d = S_IDLE;
            end else begin
               if (bus.q_fb != exp_q) begin
                  err_d = 1'b1;
               end
               exp_d = ~exp_q;
               if (tog_q == cnt_q) begin
                  state_d = S_DONE;
               end else if (gap_q == '0) begin
                  state_d = S_PULSE;
               end else begin
                  gap_cnt_d = gap_q - 1'b1;
                  state_d   = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (gap_cnt_q == '0) begin
               state_d = S_PULSE;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered copies decoded from the state being entered.
      t_out_d = (state_d == S_PULSE);
      busy_d  = (state_d == S_PULSE) || (state_d == S_CHECK) || (state_d == S_GAP);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         exp_q     <= 1'b0;
         err_q     <= 1'b0;
         tog_q     <= '0;
         t_out_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
         exp_q     <= exp_d;
         err_q     <= err_d;
         tog_q     <= tog_d;
         t_out_q   <= t_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.t_out        = t_out_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.toggles_done = tog_q;
endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Directed bench for toggle_seq_ctrl driving a behavioural toggle_ff; cycle 0 is the start
// cycle and per-cycle outputs are recorded as bit vectors indexed by cycle number.
module tb_toggle_seq_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic q_ff;
   logic fault_mode;
   int   checks = 0;
   int   errors = 0;

   toggle_seq_ctrl_if #(.CNT_W(8), .GAP_W(4)) bus ();

   toggle_seq_ctrl #(.CNT_W(8), .GAP_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) q_ff <= 1'b0;
      else       q_ff <= q_ff ^ bus.t_out;
   end

   assign bus.q_fb = fault_mode ? 1'b0 : q_ff;

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; bus.start = 1'b1; bus.num_toggles = 8'hA5; bus.gap = 4'h9; bus.abort = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks += 5;
      if (bus.t_out !== 1'b0) begin errors++; $display("FAIL reset_t_out got %b exp 0", bus.t_out); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
      if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
      if (bus.toggles_done !== 8'd0) begin errors++; $display("FAIL reset_toggles got %0d exp 0", bus.toggles_done); end
      reset = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks += 5;
      if (bus.t_out !== 1'b0) begin errors++; $display("FAIL idle_t_out got %b exp 0", bus.t_out); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL idle_done got %b exp 0", bus.done); end
      if (bus.err !== 1'b0) begin errors++; $display("FAIL idle_err got %b exp 0", bus.err); end
      if (bus.toggles_done !== 8'd0) begin errors++; $display("FAIL idle_toggles got %0d exp 0", bus.toggles_done); end
      $display("reset: outputs idle after 2-cycle reset and release");
   endtask

   task automatic test_basic();
      logic [15:0] t_rec = '0, b_rec = '0, d_rec = '0, q_rec = '0;
      @(negedge clk);
      bus.start = 1'b1; bus.num_toggles = 8'd3; bus.gap = 4'd0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         t_rec[c] = bus.t_out; b_rec[c] = bus.busy; d_rec[c] = bus.done; q_rec[c] = q_ff;
         bus.start = 1'b0;
      end
      checks += 6;
      if (t_rec !== 16'h002A) begin errors++; $display("FAIL basic_t_out got %h exp 002a", t_rec); end
      if (b_rec !== 16'h007E) begin errors++; $display("FAIL basic_busy got %h exp 007e", b_rec); end
      if (d_rec !== 16'h0080) begin errors++; $display("FAIL basic_done got %h exp 0080", d_rec); end
      if (q_rec !== 16'h07CC) begin errors++; $display("FAIL basic_q got %h exp 07cc", q_rec); end
      if (bus.toggles_done !== 8'd3) begin errors++; $display("FAIL basic_toggles got %0d exp 3", bus.toggles_done); end
      if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", bus.err); end
      $display("basic: N=3 gap=0 t_out=%h done=%h toggles=%0d", t_rec, d_rec, bus.toggles_done);
   endtask

   task automatic test_gap();
      logic [15:0] t_rec = '0, b_rec = '0, d_rec = '0;
      @(negedge clk);
      bus.start = 1'b1; bus.num_toggles = 8'd2; bus.gap = 4'd3;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         t_rec[c] = bus.t_out; b_rec[c] = bus.busy; d_rec[c] = bus.done;
         bus.start = 1'b0;
      end
      checks += 5;
      if (t_rec !== 16'h0042) begin errors++; $display("FAIL gap_t_out got %h exp 0042", t_rec); end
      if (b_rec !== 16'h00FE) begin errors++; $display("FAIL gap_busy got %h exp 00fe", b_rec); end
      if (d_rec !== 16'h0100) begin errors++; $display("FAIL gap_done got %h exp 0100", d_rec); end
      if (bus.toggles_done !== 8'd2) begin errors++; $display("FAIL gap_toggles got %0d exp 2", bus.toggles_done); end
      if (bus.err !== 1'b0) begin errors++; $display("FAIL gap_err got %b exp 0", bus.err); end
      $display("gap: N=2 gap=3 t_out=%h busy=%h done=%h", t_rec, b_rec, d_rec);
   endtask

   task automatic test_fault();
      logic [15:0] e_rec = '0, d_rec = '0;
      @(negedge clk);
      fault_mode = 1'b1;
      bus.start = 1'b1; bus.num_toggles = 8'd2; bus.gap = 4'd1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         e_rec[c] = bus.err; d_rec[c] = bus.done;
         bus.start = 1'b0;
      end
      checks += 3;
      if (e_rec !== 16'h01F8) begin errors++; $display("FAIL fault_err got %h exp 01f8", e_rec); end
      if (d_rec !== 16'h0040) begin errors++; $display("FAIL fault_done got %h exp 0040", d_rec); end
      if (bus.toggles_done !== 8'd2) begin errors++; $display("FAIL fault_toggles got %0d exp 2", bus.toggles_done); end
      $display("fault: q_fb stuck 0, err=%h done=%h", e_rec, d_rec);
      fault_mode = 1'b0;
      bus.start = 1'b1; bus.num_toggles = 8'd1; bus.gap = 4'd0;
      e_rec = '0; d_rec = '0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         e_rec[c] = bus.err; d_rec[c] = bus.done;
         bus.start = 1'b0;
      end
      checks += 2;
      if (e_rec !== 16'h0000) begin errors++; $display("FAIL fault_clear_err got %h exp 0000", e_rec); end
      if (d_rec !== 16'h0008) begin errors++; $display("FAIL fault_clear_done got %h exp 0008", d_rec); end
      $display("fault: restart with working flop, err=%h done=%h", e_rec, d_rec);
   endtask

   task automatic test_abort();
      logic [15:0] t_rec = '0, b_rec = '0, d_rec = '0;
      @(negedge clk);
      bus.start = 1'b1; bus.num_toggles = 8'd10; bus.gap = 4'd2;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         t_rec[c] = bus.t_out; b_rec[c] = bus.busy; d_rec[c] = bus.done;
         bus.start = (c == 3);
         bus.abort = (c == 8);
         if (c == 3) begin bus.num_toggles = 8'd1; bus.gap = 4'd0; end
      end
      checks += 4;
      if (t_rec !== 16'h0022) begin errors++; $display("FAIL abort_t_out got %h exp 0022", t_rec); end
      if (b_rec !== 16'h01FE) begin errors++; $display("FAIL abort_busy got %h exp 01fe", b_rec); end
      if (d_rec !== 16'h0000) begin errors++; $display("FAIL abort_done got %h exp 0000", d_rec); end
      if (bus.toggles_done !== 8'd2) begin errors++; $display("FAIL abort_toggles got %0d exp 2", bus.toggles_done); end
      $display("abort: N=10 gap=2 abort@8 t_out=%h busy=%h toggles=%0d", t_rec, b_rec, bus.toggles_done);
   endtask

   task automatic test_zero();
      logic [15:0] t_rec = '0, b_rec = '0, d_rec = '0;
      @(negedge clk);
      bus.start = 1'b1; bus.num_toggles = 8'd0; bus.gap = 4'd5;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         t_rec[c] = bus.t_out; b_rec[c] = bus.busy; d_rec[c] = bus.done;
         bus.start = 1'b0;
      end
      checks += 4;
      if (t_rec !== 16'h0000) begin errors++; $display("FAIL zero_t_out got %h exp 0000", t_rec); end
      if (b_rec !== 16'h0000) begin errors++; $display("FAIL zero_busy got %h exp 0000", b_rec); end
      if (d_rec !== 16'h0002) begin errors++; $display("FAIL zero_done got %h exp 0002", d_rec); end
      if (bus.toggles_done !== 8'd2) begin errors++; $display("FAIL zero_toggles got %0d exp 2", bus.toggles_done); end
      $display("zero: N=0 done=%h t_out=%h", d_rec, t_rec);
   endtask

   task automatic test_reset_mid_gap();
      logic [15:0] t_rec = '0, b_rec = '0, d_rec = '0;
      @(negedge clk);
      bus.start = 1'b1; bus.num_toggles = 8'd5; bus.gap = 4'd4;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         t_rec[c] = bus.t_out; b_rec[c] = bus.busy; d_rec[c] = bus.done;
         bus.start = 1'b0;
         reset = (c == 4);
      end
      checks += 5;
      if (t_rec !== 16'h0002) begin errors++; $display("FAIL rst_gap_t_out got %h exp 0002", t_rec); end
      if (b_rec !== 16'h001E) begin errors++; $display("FAIL rst_gap_busy got %h exp 001e", b_rec); end
      if (d_rec !== 16'h0000) begin errors++; $display("FAIL rst_gap_done got %h exp 0000", d_rec); end
      if (bus.toggles_done !== 8'd0) begin errors++; $display("FAIL rst_gap_toggles got %0d exp 0", bus.toggles_done); end
      if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_gap_err got %b exp 0", bus.err); end
      $display("reset_mid_gap: N=5 gap=4 reset@4 t_out=%h busy=%h", t_rec, b_rec);
   endtask

   initial begin
      reset = 1'b1;
      fault_mode = 1'b0;
      bus.start = 1'b0; bus.num_toggles = '0; bus.gap = '0; bus.abort = 1'b0;
      test_reset();
      test_basic();
      test_gap();
      test_fault();
      test_abort();
      test_zero();
      test_reset_mid_gap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
